// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
//   Shared types and level data for the spike trap engine.
//   - trap_trigger_t : one runtime-writable trigger table entry
//   - SPIKE_INIT_X/Y : spawn position of every spike (restored on reset/rearm)
//   - SPIKE_INIT_DIR : render orientation, 0 = points up, 1 = points down
//   - default_trigger: trigger table contents loaded on reset (current level)
//   The struct field widths follow COORD_BITS/VEL_BITS/SPK_COUNT, so the top
//   must be built with matching COORD_W/VEL_W/NUM_SPIKES.
// -----------------------------------------------------------------------------
package trap_pkg;

    localparam int COORD_BITS = 10;
    localparam int VEL_BITS   = 5;
    localparam int SPK_COUNT  = 24;
    localparam int TRIG_COUNT = 8;
    localparam int PARK_Y_DEF = 360;

    typedef struct packed {
        logic                       en;
        logic [COORD_BITS-1:0]      x_lo;
        logic [COORD_BITS-1:0]      x_hi;
        logic [COORD_BITS-1:0]      y_max;
        logic signed [VEL_BITS-1:0] vel;
        logic                       gravity;
        logic [SPK_COUNT-1:0]       mask;
    } trap_trigger_t;

    // Spike i spawns at X = 8 + 20*i.
    localparam logic [COORD_BITS-1:0] SPIKE_INIT_X [SPK_COUNT] = '{
        10'd8,   10'd28,  10'd48,  10'd68,  10'd88,  10'd108, 10'd128, 10'd148,
        10'd168, 10'd188, 10'd208, 10'd228, 10'd248, 10'd268, 10'd288, 10'd308,
        10'd328, 10'd348, 10'd368, 10'd388, 10'd408, 10'd428, 10'd448, 10'd468
    };

    // Spikes 0-7 hang from a ledge, 8-15 sit on the floor, 16-23 on a platform.
    localparam logic [COORD_BITS-1:0] SPIKE_INIT_Y [SPK_COUNT] = '{
        10'd215, 10'd215, 10'd215, 10'd215, 10'd215, 10'd215, 10'd215, 10'd215,
        10'd293, 10'd293, 10'd293, 10'd293, 10'd293, 10'd293, 10'd293, 10'd293,
        10'd136, 10'd136, 10'd136, 10'd136, 10'd136, 10'd136, 10'd136, 10'd136
    };

    localparam logic [SPK_COUNT-1:0] SPIKE_INIT_DIR = 24'hFF00FF;

    function automatic trap_trigger_t default_trigger(input int t);
        trap_trigger_t e;
        e = '0;
        case (t)
            0: e = '{en: 1'b1, x_lo: 10'd100, x_hi: 10'd110, y_max: 10'd479,
                     vel: 5'sd4, gravity: 1'b0, mask: 24'h000F00};
            1: e = '{en: 1'b1, x_lo: 10'd500, x_hi: 10'd520, y_max: 10'd479,
                     vel: 5'sd2, gravity: 1'b1, mask: 24'h00F000};
            2: e = '{en: 1'b1, x_lo: 10'd300, x_hi: 10'd320, y_max: 10'd479,
                     vel: -5'sd8, gravity: 1'b0, mask: 24'h0000FF};
            3: e = '{en: 1'b1, x_lo: 10'd400, x_hi: 10'd420, y_max: 10'd479,
                     vel: 5'sd1, gravity: 1'b1, mask: 24'hFF0000};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/spike_trigger_match.sv
// -----------------------------------------------------------------------------
// spike_trigger_match
//   Combinational window test for one trigger entry. hit is high when the entry
//   is enabled, has not fired yet, and the player lies inside the inclusive
//   window x_lo <= man_x <= x_hi, man_y <= y_max (all unsigned).
// Ports
//   en, x_lo, x_hi, y_max  in   fields of the trigger entry
//   fired                  in   entry already fired since reset/rearm
//   man_x, man_y           in   player position
//   hit                    out  entry matches this frame
// -----------------------------------------------------------------------------
module spike_trigger_match
    import trap_pkg::*;
(
    input  logic                  en,
    input  logic [COORD_BITS-1:0] x_lo,
    input  logic [COORD_BITS-1:0] x_hi,
    input  logic [COORD_BITS-1:0] y_max,
    input  logic                  fired,
    input  logic [COORD_BITS-1:0] man_x,
    input  logic [COORD_BITS-1:0] man_y,
    output logic                  hit
);

    assign hit = en && !fired
              && (man_x >= x_lo) && (man_x <= x_hi)
              && (man_y <= y_max);

endmodule

// File: rtl/spike_trap_engine.sv
// -----------------------------------------------------------------------------
// spike_trap_engine
//   Trigger-table driven spike controller. Each frame the player position is
//   checked against every trigger entry; a matching entry launches the spikes
//   in its mask with its velocity (constant or gravity motion). Spikes leaving
//   the play area are parked at PARK_Y.
// Ports
//   frame_clk        in   frame clock, all state on rising edge
//   Reset            in   async active-high, full reinit incl. trigger table
//   ManX, ManY       in   player position
//   Dead             in   freeze motion and trigger evaluation
//   Rearm            in   sync respawn; trigger table kept
//   cfg_we/idx/entry in   trigger table write port
//   SpikeX, SpikeY   out  packed positions, spike i at [i*COORD_W +: COORD_W]
//   Draw_direction   out  0 = points up, 1 = points down
//   Triggered        out  spike launched since reset/rearm
//   Parked           out  spike parked off-play
// -----------------------------------------------------------------------------
module spike_trap_engine
    import trap_pkg::*;
#(
    parameter int NUM_SPIKES   = SPK_COUNT,
    parameter int NUM_TRIGGERS = TRIG_COUNT,
    parameter int COORD_W      = COORD_BITS,
    parameter int VEL_W        = VEL_BITS,
    parameter int PARK_Y       = PARK_Y_DEF,
    parameter int VMAX         = 8,
    parameter int ACCEL_DIV    = 4,
    localparam int IDX_W       = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1
) (
    input  logic                          frame_clk,
    input  logic                          Reset,
    input  logic [COORD_W-1:0]            ManX,
    input  logic [COORD_W-1:0]            ManY,
    input  logic                          Dead,
    input  logic                          Rearm,
    input  logic                          cfg_we,
    input  logic [IDX_W-1:0]              cfg_idx,
    input  trap_trigger_t                 cfg_entry,
    output logic [NUM_SPIKES*COORD_W-1:0] SpikeX,
    output logic [NUM_SPIKES*COORD_W-1:0] SpikeY,
    output logic [NUM_SPIKES-1:0]         Draw_direction,
    output logic [NUM_SPIKES-1:0]         Triggered,
    output logic [NUM_SPIKES-1:0]         Parked
);

    localparam int ACC_W = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
    localparam logic [ACC_W-1:0]          ACC_LAST = ACC_W'(ACCEL_DIV - 1);
    localparam logic [COORD_W-1:0]        PARK_Y_C = COORD_W'(PARK_Y);
    localparam logic signed [COORD_W+1:0] PARK_Y_S = (COORD_W+2)'(PARK_Y);
    localparam logic signed [VEL_W-1:0]   VMAX_P   = VEL_W'(VMAX);
    localparam logic signed [VEL_W-1:0]   VMAX_N   = VEL_W'(-VMAX);
    localparam logic signed [VEL_W-1:0]   ONE_V    = VEL_W'(1);

    trap_trigger_t              table_q [NUM_TRIGGERS];
    trap_trigger_t              table_d [NUM_TRIGGERS];
    logic [NUM_TRIGGERS-1:0]    fired_q, fired_d;
    logic [NUM_TRIGGERS-1:0]    hit;

    logic [COORD_W-1:0]         y_q   [NUM_SPIKES];
    logic [COORD_W-1:0]         y_d   [NUM_SPIKES];
    logic signed [VEL_W-1:0]    vel_q [NUM_SPIKES];
    logic signed [VEL_W-1:0]    vel_d [NUM_SPIKES];
    logic [NUM_SPIKES-1:0]      trig_q, trig_d;
    logic [NUM_SPIKES-1:0]      park_q, park_d;
    logic [NUM_SPIKES-1:0]      grav_q, grav_d;
    logic [NUM_SPIKES-1:0]      up_q, up_d;     // launch sign, 1 = upward
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       acc_wrap;

    logic                       launch      [NUM_SPIKES];
    logic signed [VEL_W-1:0]    launch_vel  [NUM_SPIKES];
    logic                       launch_grav [NUM_SPIKES];
    logic signed [COORD_W+1:0]  next_y      [NUM_SPIKES];

    for (genvar t = 0; t < NUM_TRIGGERS; t++) begin : g_match
        spike_trigger_match u_match (
            .en    (table_q[t].en),
            .x_lo  (table_q[t].x_lo),
            .x_hi  (table_q[t].x_hi),
            .y_max (table_q[t].y_max),
            .fired (fired_q[t]),
            .man_x (ManX),
            .man_y (ManY),
            .hit   (hit[t])
        );
    end

    for (genvar i = 0; i < NUM_SPIKES; i++) begin : g_out
        assign SpikeX[i*COORD_W +: COORD_W] = SPIKE_INIT_X[i];
        assign SpikeY[i*COORD_W +: COORD_W] = y_q[i];
    end

    assign Draw_direction = SPIKE_INIT_DIR;
    assign Triggered      = trig_q;
    assign Parked         = park_q;
    assign acc_wrap       = (acc_q == ACC_LAST);

    // Per-spike priority resolve: scanning from the top index down leaves the
    // lowest matching trigger as the winner.
    always_comb begin
        for (int i = 0; i < NUM_SPIKES; i++) begin
            launch[i]      = 1'b0;
            launch_vel[i]  = '0;
            launch_grav[i] = 1'b0;
            for (int t = NUM_TRIGGERS - 1; t >= 0; t--) begin
                if (hit[t] && table_q[t].mask[i]) begin
                    launch[i]      = 1'b1;
                    launch_vel[i]  = table_q[t].vel;
                    launch_grav[i] = table_q[t].gravity;
                end
            end
        end
    end

    // Two guard bits keep the sum free of wrap-around so both exits are seen.
    always_comb begin
        for (int i = 0; i < NUM_SPIKES; i++) begin
            next_y[i] = $signed({2'b00, y_q[i]})
                      + $signed({{(COORD_W+2-VEL_W){vel_q[i][VEL_W-1]}}, vel_q[i]});
        end
    end

    always_comb begin
        table_d = table_q;
        fired_d = fired_q;
        y_d     = y_q;
        vel_d   = vel_q;
        trig_d  = trig_q;
        park_d  = park_q;
        grav_d  = grav_q;
        up_d    = up_q;
        acc_d   = acc_q;

        // Evaluation this edge uses table_q, so a new entry acts next edge.
        if (cfg_we && (int'(cfg_idx) < NUM_TRIGGERS)) begin
            table_d[cfg_idx] = cfg_entry;
        end

        if (Rearm) begin
            fired_d = '0;
            trig_d  = '0;
            park_d  = '0;
            grav_d  = '0;
            up_d    = '0;
            acc_d   = '0;
            for (int i = 0; i < NUM_SPIKES; i++) begin
                y_d[i]   = SPIKE_INIT_Y[i];
                vel_d[i] = '0;
            end
        end else if (!Dead) begin
            acc_d   = acc_wrap ? '0 : acc_q + 1'b1;
            fired_d = fired_q | hit;
            for (int i = 0; i < NUM_SPIKES; i++) begin
                if (trig_q[i] && !park_q[i]) begin
                    if (grav_q[i] && acc_wrap) begin
                        if (up_q[i]) begin
                            if (vel_q[i] > VMAX_N) vel_d[i] = vel_q[i] - ONE_V;
                        end else begin
                            if (vel_q[i] < VMAX_P) vel_d[i] = vel_q[i] + ONE_V;
                        end
                    end
                    if (next_y[i][COORD_W+1] || (next_y[i] >= PARK_Y_S)) begin
                        y_d[i]    = PARK_Y_C;
                        vel_d[i]  = '0;
                        park_d[i] = 1'b1;
                    end else begin
                        y_d[i] = next_y[i][COORD_W-1:0];
                    end
                end else if (!trig_q[i] && launch[i]) begin
                    // Launch edge loads velocity only; motion starts next edge.
                    vel_d[i]  = launch_vel[i];
                    trig_d[i] = 1'b1;
                    grav_d[i] = launch_grav[i];
                    up_d[i]   = launch_vel[i][VEL_W-1];
                end
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int t = 0; t < NUM_TRIGGERS; t++) begin
                table_q[t] <= default_trigger(t);
            end
            for (int i = 0; i < NUM_SPIKES; i++) begin
                y_q[i]   <= SPIKE_INIT_Y[i];
                vel_q[i] <= '0;
            end
            fired_q <= '0;
            trig_q  <= '0;
            park_q  <= '0;
            grav_q  <= '0;
            up_q    <= '0;
            acc_q   <= '0;
        end else begin
            table_q <= table_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            fired_q <= fired_d;
            trig_q  <= trig_d;
            park_q  <= park_d;
            grav_q  <= grav_d;
            up_q    <= up_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: tb/tb_spike_trap_engine.sv
module tb_spike_trap_engine;
    import trap_pkg::*;

    logic          frame_clk;
    logic          Reset;
    logic [9:0]    ManX, ManY;
    logic          Dead, Rearm, cfg_we;
    logic [2:0]    cfg_idx;
    trap_trigger_t cfg_entry;
    logic [239:0]  SpikeX, SpikeY;
    logic [23:0]   Draw_direction, Triggered, Parked;

    int checks = 0;
    int errors = 0;

    spike_trap_engine dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .ManX           (ManX),
        .ManY           (ManY),
        .Dead           (Dead),
        .Rearm          (Rearm),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_entry      (cfg_entry),
        .SpikeX         (SpikeX),
        .SpikeY         (SpikeY),
        .Draw_direction (Draw_direction),
        .Triggered      (Triggered),
        .Parked         (Parked)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    function automatic logic [9:0] sy(input int i);
        return SpikeY[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sx(input int i);
        return SpikeX[i*10 +: 10];
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; ManX = 10'd0; ManY = 10'd1000;
        Dead = 1'b0; Rearm = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_entry = '0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic set_cfg(input int idx, input int xl, input int xh, input int ym,
                           input int v, input logic g, input logic [23:0] m);
        cfg_idx           = 3'(idx);
        cfg_entry.en      = 1'b1;
        cfg_entry.x_lo    = 10'(xl);
        cfg_entry.x_hi    = 10'(xh);
        cfg_entry.y_max   = 10'(ym);
        cfg_entry.vel     = 5'(v);
        cfg_entry.gravity = g;
        cfg_entry.mask    = m;
    endtask

    task automatic write_cfg(input int idx, input int xl, input int xh, input int ym,
                             input int v, input logic g, input logic [23:0] m);
        set_cfg(idx, xl, xh, ym, v, g, m);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sy(15) !== 10'd293) begin errors++; $display("FAIL reset_y15 got %0d exp 293", sy(15)); end
        checks++; if (sy(7) !== 10'd215) begin errors++; $display("FAIL reset_y7 got %0d exp 215", sy(7)); end
        checks++; if (sy(16) !== 10'd136) begin errors++; $display("FAIL reset_y16 got %0d exp 136", sy(16)); end
        checks++; if (sx(15) !== 10'd308) begin errors++; $display("FAIL reset_x15 got %0d exp 308", sx(15)); end
        checks++; if (Draw_direction !== 24'hFF00FF) begin errors++; $display("FAIL reset_dir got %h exp ff00ff", Draw_direction); end
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL reset_trig got %h exp 0", Triggered); end
        checks++; if (Parked !== 24'h0) begin errors++; $display("FAIL reset_park got %h exp 0", Parked); end
    endtask

    task automatic test_window_edge();
        do_reset();
        ManX = 10'd208; ManY = 10'd100;
        write_cfg(4, 208, 212, 479, 1, 1'b0, 24'h008000);
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL win_same_edge got %h exp 0", Triggered); end
        ManX = 10'd207;
        tick();
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL win_x207 got %h exp 0", Triggered); end
        ManX = 10'd208; ManY = 10'd480;
        tick();
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL win_y480 got %h exp 0", Triggered); end
        ManY = 10'd479;
        tick();
        checks++; if (Triggered !== 24'h008000) begin errors++; $display("FAIL win_x208 got %h exp 008000", Triggered); end
        checks++; if (sy(15) !== 10'd293) begin errors++; $display("FAIL win_latency got %0d exp 293", sy(15)); end
        ManX = 10'd0;
        tick();
        checks++; if (sy(15) !== 10'd294) begin errors++; $display("FAIL win_move got %0d exp 294", sy(15)); end
    endtask

    task automatic test_reset_mid_motion();
        cfg_entry = '0;
        cfg_idx = 3'd0;
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        tick();
        tick();
        checks++; if (sy(15) !== 10'd297) begin errors++; $display("FAIL mid_y15 got %0d exp 297", sy(15)); end
        Reset = 1'b1;
        #1;
        checks++; if (sy(15) !== 10'd293) begin errors++; $display("FAIL async_y15 got %0d exp 293", sy(15)); end
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL async_trig got %h exp 0", Triggered); end
        tick();
        Reset = 1'b0;
        ManX = 10'd105; ManY = 10'd100;
        tick();
        checks++; if (Triggered !== 24'h000F00) begin errors++; $display("FAIL table_restored got %h exp 000f00", Triggered); end
        ManX = 10'd0;
        tick();
        checks++; if (sy(8) !== 10'd297) begin errors++; $display("FAIL restored_move got %0d exp 297", sy(8)); end
    endtask

    task automatic test_upward_park();
        do_reset();
        ManX = 10'd310; ManY = 10'd100;
        tick();
        checks++; if (Triggered !== 24'h0000FF) begin errors++; $display("FAIL up_trig got %h exp 0000ff", Triggered); end
        ManX = 10'd0;
        repeat (26) tick();
        checks++; if (sy(7) !== 10'd7) begin errors++; $display("FAIL up_y7 got %0d exp 7", sy(7)); end
        checks++; if (Parked !== 24'h0) begin errors++; $display("FAIL up_not_parked got %h exp 0", Parked); end
        tick();
        checks++; if (sy(7) !== 10'd360) begin errors++; $display("FAIL up_park_y got %0d exp 360", sy(7)); end
        checks++; if (Parked !== 24'h0000FF) begin errors++; $display("FAIL up_parked got %h exp 0000ff", Parked); end
        tick();
        checks++; if (sy(7) !== 10'd360) begin errors++; $display("FAIL up_park_hold got %0d exp 360", sy(7)); end
        checks++; if (sx(7) !== 10'd148) begin errors++; $display("FAIL up_x7 got %0d exp 148", sx(7)); end
    endtask

    task automatic test_conflict();
        do_reset();
        write_cfg(2, 50, 60, 479, 1, 1'b0, 24'h030000);
        write_cfg(5, 50, 60, 479, 3, 1'b0, 24'h050000);
        ManY = 10'd100; ManX = 10'd61;
        tick();
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL conf_x61 got %h exp 0", Triggered); end
        ManX = 10'd60;
        tick();
        checks++; if (Triggered !== 24'h070000) begin errors++; $display("FAIL conf_trig got %h exp 070000", Triggered); end
        ManX = 10'd0;
        tick();
        checks++; if (sy(16) !== 10'd137) begin errors++; $display("FAIL conf_y16 got %0d exp 137", sy(16)); end
        checks++; if (sy(17) !== 10'd137) begin errors++; $display("FAIL conf_y17 got %0d exp 137", sy(17)); end
        checks++; if (sy(18) !== 10'd139) begin errors++; $display("FAIL conf_y18 got %0d exp 139", sy(18)); end
        write_cfg(5, 50, 60, 479, 3, 1'b0, 24'h080000);
        write_cfg(2, 50, 60, 479, 1, 1'b0, 24'h100000);
        ManX = 10'd55;
        tick();
        checks++; if (Triggered !== 24'h070000) begin errors++; $display("FAIL conf_fired got %h exp 070000", Triggered); end
    endtask

    task automatic test_dead();
        do_reset();
        ManX = 10'd410; ManY = 10'd100;
        tick();
        checks++; if (Triggered !== 24'hFF0000) begin errors++; $display("FAIL dead_launch got %h exp ff0000", Triggered); end
        ManX = 10'd0;
        repeat (9) tick();
        checks++; if (sy(16) !== 10'd153) begin errors++; $display("FAIL grav_y got %0d exp 153", sy(16)); end
        Dead = 1'b1; ManX = 10'd105;
        repeat (10) tick();
        checks++; if (sy(16) !== 10'd153) begin errors++; $display("FAIL dead_hold got %0d exp 153", sy(16)); end
        checks++; if (Triggered !== 24'hFF0000) begin errors++; $display("FAIL dead_no_trig got %h exp ff0000", Triggered); end
        Dead = 1'b0; ManX = 10'd0;
        tick();
        checks++; if (sy(16) !== 10'd156) begin errors++; $display("FAIL resume1 got %0d exp 156", sy(16)); end
        tick();
        checks++; if (sy(16) !== 10'd159) begin errors++; $display("FAIL resume2 got %0d exp 159", sy(16)); end
        tick();
        checks++; if (sy(16) !== 10'd163) begin errors++; $display("FAIL resume3 got %0d exp 163", sy(16)); end
    endtask

    task automatic test_rearm();
        do_reset();
        ManX = 10'd105; ManY = 10'd100;
        tick();
        ManX = 10'd0;
        repeat (3) tick();
        checks++; if (sy(8) !== 10'd305) begin errors++; $display("FAIL pre_rearm_y8 got %0d exp 305", sy(8)); end
        Rearm = 1'b1;
        set_cfg(6, 600, 610, 479, 2, 1'b0, 24'h000001);
        cfg_we = 1'b1;
        tick();
        Rearm = 1'b0; cfg_we = 1'b0;
        checks++; if (sy(8) !== 10'd293) begin errors++; $display("FAIL rearm_y8 got %0d exp 293", sy(8)); end
        checks++; if (Triggered !== 24'h0) begin errors++; $display("FAIL rearm_trig got %h exp 0", Triggered); end
        ManX = 10'd105;
        tick();
        checks++; if (Triggered !== 24'h000F00) begin errors++; $display("FAIL refire got %h exp 000f00", Triggered); end
        ManX = 10'd605;
        tick();
        checks++; if (Triggered !== 24'h000F01) begin errors++; $display("FAIL rearm_cfg got %h exp 000f01", Triggered); end
        checks++; if (sy(8) !== 10'd297) begin errors++; $display("FAIL refire_move got %0d exp 297", sy(8)); end
    endtask

    initial begin
        test_reset();
        test_window_edge();
        test_reset_mid_motion();
        test_upward_park();
        test_conflict();
        test_dead();
        test_rearm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
